vga_sprite_engine: RTL and testbench
====================================

// Module: vga_sprite_engine
// PURPOSE
//  Parametrised VGA timing generator with one movable, bitmap-defined sprite and a screen border.
//  Runs on CLK100MHz and derives the pixel rate with a clock enable, so it needs no divided clock.
//  Sits between the PS/2 key decoder, which drives the mv_*/stop pulses, and the VGA pins.
//  Adds to the fixed-timing sprite demo: writable bitmap, velocity state, clamp/bounce modes and a frame strobe.
// PARAMETERS
//  CLK_DIV   4    CLK100MHz cycles per pixel (>=2)
//  COLOR_W   3    bits per colour channel
//  H_PIXELS  640  visible pixels/line; H_FP 16, H_PULSE 96, H_BP 48 (H_TOTAL=800)
//  V_PIXELS  480  visible lines/frame; V_FP 10, V_PULSE 2, V_BP 33 (V_TOTAL=525)
//  H_POL     0    hsync active level; V_POL 0 vsync active level
//  SPR_SIZE  16   sprite is SPR_SIZE x SPR_SIZE pixels (<=32)
//  STEP      1    pixels moved per frame while velocity is non-zero
//  INIT_X    320  reset sprite top-left x; INIT_Y 240 reset sprite top-left y
// PORTS
//  CLK100MHz   in   1            system clock, 100 MHz
//  reset       in   1            synchronous, active-high
//  mv_up/mv_dn/mv_lf/mv_rt in 1  one-cycle direction request pulses
//  stop        in   1            pulse: zero both velocities
//  bounce_en   in   1            1=bounce at edges, 0=clamp and stop
//  fg_rgb      in   3*COLOR_W    sprite colour {r,g,b}; border_rgb in 3*COLOR_W border colour
//  bm_we       in   1            bitmap row write strobe
//  bm_row      in   clog2(SPR_SIZE)  bitmap row address
//  bm_data     in   SPR_SIZE     row bits; MSB = leftmost pixel
//  vga_r/g/b   out  COLOR_W each pixel colour
//  vga_hs/vga_vs out 1           sync outputs
//  frame_start out  1            one CLK100MHz pulse at the start of vertical blank
//  spr_x/spr_y out  10           current sprite top-left
// BEHAVIOUR
//  Reset is synchronous, active-high; clock CLK100MHz.
//  Reset values: div, h_cnt, v_cnt = 0; rgb = 0; hs=~H_POL; vs=~V_POL; frame_start=0;
//   spr_x=INIT_X, spr_y=INIT_Y; vx=vy=0; every bitmap bit=1. Reset mid-frame restarts at h=0,v=0 on the next edge.
//  Pixel enable: div counts 0..CLK_DIV-1; pix_ce=1 when div==CLK_DIV-1. Counters change only on pix_ce.
//  h_cnt wraps H_TOTAL-1->0. On that wrap, v_cnt increments and wraps V_TOTAL-1->0.
//  All outputs registered on pix_ce, 1 pixel after counters; hs/vs/rgb share the same latency.
//  hs active when H_PIXELS+H_FP <= h_cnt < H_PIXELS+H_FP+H_PULSE; vs uses the analogous v_cnt window.
//  Colour priority when visible (h<H_PIXELS, v<V_PIXELS):
//   1. border_rgb on col 0, col H_PIXELS-1, row 0 or row V_PIXELS-1.
//   2. fg_rgb if spr_x<=h<spr_x+SPR_SIZE, spr_y<=v<spr_y+SPR_SIZE and bitmap[v-spr_y][SPR_SIZE-1-(h-spr_x)]==1.
//   3. Otherwise 0. Blanking region is always 0.
//  Bitmap: SPR_SIZE registers of SPR_SIZE bits. bm_we writes bm_row on any clock; visible next cycle.
//   Writes during active video are allowed; tearing is acceptable. bm_row>=SPR_SIZE is ignored.
//  Velocity (any clock, not gated by pix_ce): mv_lf sets vx=-STEP; mv_rt sets vx=+STEP; mv_lf&mv_rt together leaves vx unchanged.
//   Same rules for vy: mv_up sets -STEP, mv_dn sets +STEP.
//   stop zeroes vx and vy and overrides any simultaneous mv_*.
//  frame_start and position update: both happen on the pix_ce where h_cnt=0 and v_cnt=V_PIXELS.
//   Position update: nx = spr_x+vx, computed signed in 11 bits; legal range 0..H_PIXELS-SPR_SIZE.
//   If nx is outside the range, spr_x is clamped to the limit; vx then becomes -vx if bounce_en=1, else 0.
//   y is handled the same way with range 0..V_PIXELS-SPR_SIZE.
//   A mv_* pulse in the same cycle as the update takes effect from the next frame.
// TESTING
//  T1 timing: defaults, after reset:
//   hs period 3200 clocks, hs low 384 clocks; vs period 1,680,000 clocks, vs low 6400 clocks; frame_start once per frame.
//  T2 render: bitmap reset, fg=9'h1FF, border=9'h1C0:
//   pixel(320,240) and (335,255) = 1FF; pixel(319,240) and (336,240) = 0; pixel(0,0) = 1C0.
//  T3 clamp: bounce_en=0, mv_rt once:
//   spr_x = 321, 322, ... reaching 624 after 304 frames; frame 305 keeps 624 with vx=0.
//  T4 bounce: bounce_en=1, mv_lf once:
//   spr_x reaches 0 after 320 frames; next frame stays 0 with vx=+1; following frame spr_x=1.
//  T5 bitmap/stop: bm_we with bm_row=0, bm_data=0: row v=240 of the sprite renders 0 next frame.
//   mv_dn together with stop: vy stays 0.
//  T6 reset mid-op: reset 1 cycle at h=100,v=200 while moving:
//   next edge hs/vs inactive, rgb 0, spr=(320,240), bitmap all ones.

Source files
------------

// File: rtl/vga_sprite_engine_if.sv
// rtl/vga_sprite_engine_if.sv - control, bitmap and video signals of the sprite engine
interface vga_sprite_engine_if #(
    parameter int COLOR_W  = 3,
    parameter int SPR_SIZE = 16
);
    localparam int ROW_W = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1;

    logic                   mv_up;
    logic                   mv_dn;
    logic                   mv_lf;
    logic                   mv_rt;
    logic                   stop;
    logic                   bounce_en;
    logic [3*COLOR_W-1:0]   fg_rgb;
    logic [3*COLOR_W-1:0]   border_rgb;
    logic                   bm_we;
    logic [ROW_W-1:0]       bm_row;
    logic [SPR_SIZE-1:0]    bm_data;
    logic [COLOR_W-1:0]     vga_r;
    logic [COLOR_W-1:0]     vga_g;
    logic [COLOR_W-1:0]     vga_b;
    logic                   vga_hs;
    logic                   vga_vs;
    logic                   frame_start;
    logic [9:0]             spr_x;
    logic [9:0]             spr_y;

    modport master (
        output mv_up, mv_dn, mv_lf, mv_rt, stop, bounce_en,
        output fg_rgb, border_rgb, bm_we, bm_row, bm_data,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, spr_x, spr_y
    );

    modport slave (
        input  mv_up, mv_dn, mv_lf, mv_rt, stop, bounce_en,
        input  fg_rgb, border_rgb, bm_we, bm_row, bm_data,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, spr_x, spr_y
    );
endinterface

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - VGA timing with one movable bitmap sprite and a border
module vga_sprite_engine #(
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 3,
    parameter int H_PIXELS = 640,
    parameter int H_FP     = 16,
    parameter int H_PULSE  = 96,
    parameter int H_BP     = 48,
    parameter int V_PIXELS = 480,
    parameter int V_FP     = 10,
    parameter int V_PULSE  = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int SPR_SIZE = 16,
    parameter int STEP     = 1,
    parameter int INIT_X   = 320,
    parameter int INIT_Y   = 240
) (
    input  logic              CLK100MHz,
    input  logic              reset,
    vga_sprite_engine_if.slave bus
);
    localparam int H_TOTAL = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_PIXELS + V_FP + V_PULSE + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam logic signed [10:0] X_MAX  = 11'(H_PIXELS - SPR_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(V_PIXELS - SPR_SIZE);
    localparam logic signed [10:0] STEP_P = 11'(STEP);
    localparam logic signed [10:0] STEP_N = 11'(-STEP);

    typedef struct packed {
        logic [9:0]  pos;
        logic [10:0] vel;
    } axis_t;

    // One frame of motion on one axis: clamp to [0, lim], then reverse or kill velocity.
    function automatic axis_t step_axis(input logic [9:0] pos, input logic signed [10:0] vel,
                                        input logic signed [10:0] lim, input logic bounce);
        axis_t r;
        logic signed [10:0] nx;
        nx    = $signed({1'b0, pos}) + vel;
        r.pos = nx[9:0];
        r.vel = vel;
        if (nx < 11'sd0) begin
            r.pos = '0;
            r.vel = bounce ? -vel : '0;
        end else if (nx > lim) begin
            r.pos = lim[9:0];
            r.vel = bounce ? -vel : '0;
        end
        return r;
    endfunction

    logic [DIV_W-1:0]     div;
    logic                 pix_ce;
    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic [SPR_SIZE-1:0]  bitmap [SPR_SIZE];
    logic [9:0]           spr_x, spr_y;
    logic signed [10:0]   vx, vy;
    logic [RGB_W-1:0]     rgb;
    logic                 hs, vs, frame_start;

    logic                 visible, on_border, in_x, in_y, spr_on, at_update;
    logic                 hs_next, vs_next;
    logic [10:0]          h_ext, v_ext, sx_ext, sy_ext;
    logic [SW-1:0]        dx, dy, col;
    logic [SPR_SIZE-1:0]  row_bits;
    logic [RGB_W-1:0]     rgb_next;
    axis_t                ax, ay;
    logic [9:0]           spr_x_next, spr_y_next;
    logic signed [10:0]   vx_next, vy_next;

    assign pix_ce = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            div <= '0;
        end else if (pix_ce) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        h_ext     = 11'(h_cnt);
        v_ext     = 11'(v_cnt);
        sx_ext    = {1'b0, spr_x};
        sy_ext    = {1'b0, spr_y};
        visible   = (h_cnt < HW'(H_PIXELS)) && (v_cnt < VW'(V_PIXELS));
        on_border = (h_cnt == '0) || (h_cnt == HW'(H_PIXELS - 1)) ||
                    (v_cnt == '0) || (v_cnt == VW'(V_PIXELS - 1));
        in_x      = (h_ext >= sx_ext) && (h_ext < sx_ext + 11'(SPR_SIZE));
        in_y      = (v_ext >= sy_ext) && (v_ext < sy_ext + 11'(SPR_SIZE));
        dx        = SW'(h_ext - sx_ext);
        dy        = SW'(v_ext - sy_ext);
        col       = SW'(SPR_SIZE - 1) - dx;
        row_bits  = bitmap[dy];
        spr_on    = in_x && in_y && row_bits[col];
        rgb_next  = '0;
        if (visible) begin
            if (on_border) begin
                rgb_next = bus.border_rgb;
            end else if (spr_on) begin
                rgb_next = bus.fg_rgb;
            end
        end
        hs_next = ((h_cnt >= HW'(H_PIXELS + H_FP)) &&
                   (h_cnt <  HW'(H_PIXELS + H_FP + H_PULSE))) ? H_POL : ~H_POL;
        vs_next = ((v_cnt >= VW'(V_PIXELS + V_FP)) &&
                   (v_cnt <  VW'(V_PIXELS + V_FP + V_PULSE))) ? V_POL : ~V_POL;
        at_update = pix_ce && (h_cnt == '0) && (v_cnt == VW'(V_PIXELS));
    end

    // Key pulses override the bounce/clamp result, so a same-cycle request governs the next frame.
    always_comb begin
        ax         = step_axis(spr_x, vx, X_MAX, bus.bounce_en);
        ay         = step_axis(spr_y, vy, Y_MAX, bus.bounce_en);
        spr_x_next = spr_x;
        spr_y_next = spr_y;
        vx_next    = vx;
        vy_next    = vy;
        if (at_update) begin
            spr_x_next = ax.pos;
            spr_y_next = ay.pos;
            vx_next    = ax.vel;
            vy_next    = ay.vel;
        end
        if (bus.stop) begin
            vx_next = '0;
            vy_next = '0;
        end else begin
            if (bus.mv_lf && !bus.mv_rt) vx_next = STEP_N;
            if (bus.mv_rt && !bus.mv_lf) vx_next = STEP_P;
            if (bus.mv_up && !bus.mv_dn) vy_next = STEP_N;
            if (bus.mv_dn && !bus.mv_up) vy_next = STEP_P;
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            spr_x <= 10'(INIT_X);
            spr_y <= 10'(INIT_Y);
            vx    <= '0;
            vy    <= '0;
        end else begin
            spr_x <= spr_x_next;
            spr_y <= spr_y_next;
            vx    <= vx_next;
            vy    <= vy_next;
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            for (int i = 0; i < SPR_SIZE; i++) begin
                bitmap[i] <= '1;
            end
        end else if (bus.bm_we && ({1'b0, bus.bm_row} < (SW + 1)'(SPR_SIZE))) begin
            bitmap[bus.bm_row] <= bus.bm_data;
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (reset) begin
            rgb         <= '0;
            hs          <= ~H_POL;
            vs          <= ~V_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= at_update;
            if (pix_ce) begin
                rgb <= rgb_next;
                hs  <= hs_next;
                vs  <= vs_next;
            end
        end
    end

    assign bus.vga_r       = rgb[RGB_W-1 -: COLOR_W];
    assign bus.vga_g       = rgb[2*COLOR_W-1 -: COLOR_W];
    assign bus.vga_b       = rgb[COLOR_W-1:0];
    assign bus.vga_hs      = hs;
    assign bus.vga_vs      = vs;
    assign bus.frame_start = frame_start;
    assign bus.spr_x       = spr_x;
    assign bus.spr_y       = spr_y;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - randomized and directed checks of vga_sprite_engine against a pixel-index model
module tb_vga_sprite_engine;
    localparam int CLK_DIV = 2, COLOR_W = 3;
    localparam int H_PIXELS = 32, H_FP = 2, H_PULSE = 3, H_BP = 3;
    localparam int V_PIXELS = 24, V_FP = 1, V_PULSE = 2, V_BP = 2;
    localparam bit H_POL = 1'b0, V_POL = 1'b1;
    localparam int SPR = 8, STEP = 2, INIT_X = 13, INIT_Y = 9;
    localparam int H_TOTAL = H_PIXELS + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_PIXELS + V_FP + V_PULSE + V_BP;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    vga_sprite_engine_if #(.COLOR_W(COLOR_W), .SPR_SIZE(SPR)) bus ();

    vga_sprite_engine #(
        .CLK_DIV(CLK_DIV), .COLOR_W(COLOR_W),
        .H_PIXELS(H_PIXELS), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
        .V_PIXELS(V_PIXELS), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL), .SPR_SIZE(SPR), .STEP(STEP),
        .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) dut (
        .CLK100MHz(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: t counts edges since reset; pixel p is shown after edge (p+1)*CLK_DIV.
    int         t = 0;
    bit         model_valid = 0;
    bit         out_valid = 0;
    int         out_h = 0, out_v = 0;
    logic [8:0] e_rgb;
    logic       e_hs, e_vs, e_fs;
    int         e_sx, e_sy, m_vx, m_vy;
    logic [7:0] m_bm [SPR];
    int         mh, mv, mp, nvx, nvy;

    function automatic logic [8:0] model_pixel(input int h, input int v);
        if (h >= H_PIXELS || v >= V_PIXELS) return 9'h0;
        if (h == 0 || h == H_PIXELS - 1 || v == 0 || v == V_PIXELS - 1) return bus.border_rgb;
        if (h >= e_sx && h < e_sx + SPR && v >= e_sy && v < e_sy + SPR &&
            m_bm[v - e_sy][SPR - 1 - (h - e_sx)]) return bus.fg_rgb;
        return 9'h0;
    endfunction

    task automatic move_axis(inout int pos, input int vel, input int lim, output int nvel);
        int nx;
        nx = pos + vel;
        nvel = vel;
        if (nx < 0) begin
            pos = 0;
            nvel = bus.bounce_en ? -vel : 0;
        end else if (nx > lim) begin
            pos = lim;
            nvel = bus.bounce_en ? -vel : 0;
        end else begin
            pos = nx;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            t = 0; out_valid = 0; model_valid = 1;
            e_rgb = 9'h0; e_hs = !H_POL; e_vs = !V_POL; e_fs = 0;
            e_sx = INIT_X; e_sy = INIT_Y; m_vx = 0; m_vy = 0;
            for (int i = 0; i < SPR; i++) m_bm[i] = 8'hFF;
        end else if (model_valid) begin
            t++;
            e_fs = 0;
            nvx = m_vx;
            nvy = m_vy;
            if (t % CLK_DIV == 0) begin
                mp = t / CLK_DIV - 1;
                mh = mp % H_TOTAL;
                mv = (mp / H_TOTAL) % V_TOTAL;
                e_rgb = model_pixel(mh, mv);
                e_hs = (mh >= H_PIXELS + H_FP && mh < H_PIXELS + H_FP + H_PULSE) ? H_POL : !H_POL;
                e_vs = (mv >= V_PIXELS + V_FP && mv < V_PIXELS + V_FP + V_PULSE) ? V_POL : !V_POL;
                out_h = mh; out_v = mv; out_valid = 1;
                if (mh == 0 && mv == V_PIXELS) begin
                    e_fs = 1;
                    move_axis(e_sx, m_vx, H_PIXELS - SPR, nvx);
                    move_axis(e_sy, m_vy, V_PIXELS - SPR, nvy);
                end
            end
            if (bus.stop) begin
                nvx = 0; nvy = 0;
            end else begin
                if (bus.mv_lf != bus.mv_rt) nvx = bus.mv_lf ? -STEP : STEP;
                if (bus.mv_up != bus.mv_dn) nvy = bus.mv_up ? -STEP : STEP;
            end
            m_vx = nvx;
            m_vy = nvy;
            if (bus.bm_we) m_bm[bus.bm_row] = bus.bm_data;
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            compared++;
            if ({bus.vga_r, bus.vga_g, bus.vga_b} !== e_rgb || bus.vga_hs !== e_hs ||
                bus.vga_vs !== e_vs || bus.frame_start !== e_fs ||
                bus.spr_x !== 10'(e_sx) || bus.spr_y !== 10'(e_sy)) begin
                mismatched++;
                $display("FAIL model t=%0d rgb=%h/%h hs=%b/%b vs=%b/%b fs=%b/%b x=%0d/%0d y=%0d/%0d (got/want)",
                         t, {bus.vga_r, bus.vga_g, bus.vga_b}, e_rgb, bus.vga_hs, e_hs,
                         bus.vga_vs, e_vs, bus.frame_start, e_fs, bus.spr_x, e_sx, bus.spr_y, e_sy);
                if (mismatched >= 50) finish_run();
            end
        end
    end

    task automatic check(input string nm, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic clear_inputs();
        bus.mv_up = 0; bus.mv_dn = 0; bus.mv_lf = 0; bus.mv_rt = 0; bus.stop = 0; bus.bm_we = 0;
    endtask

    task automatic pulse(input bit up, input bit dn, input bit lf, input bit rt, input bit st);
        bus.mv_up = up; bus.mv_dn = dn; bus.mv_lf = lf; bus.mv_rt = rt; bus.stop = st;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic wait_frame();
        int k = 0;
        @(negedge clk);
        while (!e_fs && k < FRAME_CYC + 10) begin @(negedge clk); k++; end
        if (!e_fs) check("wait_frame_timeout", 0, 1);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) wait_frame();
    endtask

    task automatic wait_pixel(input int x, input int y);
        int k = 0;
        @(negedge clk);
        while (!(out_valid && out_h == x && out_v == y) && k < FRAME_CYC + 10) begin
            @(negedge clk); k++;
        end
        if (k >= FRAME_CYC + 10) check("wait_pixel_timeout", 0, 1);
    endtask

    task automatic check_pix(input int x, input int y, input logic [8:0] want);
        wait_pixel(x, y);
        check($sformatf("pixel(%0d,%0d)", x, y), int'({bus.vga_r, bus.vga_g, bus.vga_b}), int'(want));
    endtask

    function automatic bit next_is_update();
        int tn, p;
        tn = t + 1;
        if (tn % CLK_DIV != 0) return 0;
        p = tn / CLK_DIV - 1;
        return (p % H_TOTAL == 0) && ((p / H_TOTAL) % V_TOTAL == V_PIXELS);
    endfunction

    function automatic logic sync_sig(input bit use_vs);
        return use_vs ? bus.vga_vs : bus.vga_hs;
    endfunction

    task automatic measure(input bit use_vs, input logic act, input int per, input int act_len, input string nm);
        int k = 0, n_act = 0, n_per = 0, n_fs = 0;
        int lim = 2 * FRAME_CYC + 100;
        while (sync_sig(use_vs) === act && k < lim) begin @(negedge clk); k++; end
        while (sync_sig(use_vs) !== act && k < lim) begin @(negedge clk); k++; end
        while (sync_sig(use_vs) === act && k < lim) begin
            n_act++; n_per++; n_fs += int'(bus.frame_start); @(negedge clk); k++;
        end
        while (sync_sig(use_vs) !== act && k < lim) begin
            n_per++; n_fs += int'(bus.frame_start); @(negedge clk); k++;
        end
        check({nm, "_active_clocks"}, n_act, act_len);
        check({nm, "_period_clocks"}, n_per, per);
        if (use_vs) check("frame_start_per_frame", n_fs, 1);
    endtask

    initial begin
        #(2_000_000);
        check("watchdog_expired", 0, 1);
        finish_run();
    end

    initial begin
        clear_inputs();
        bus.bounce_en = 1; bus.bm_row = '0; bus.bm_data = '0;
        bus.fg_rgb = 9'h1FF; bus.border_rgb = 9'h1C0;
        repeat (3) @(negedge clk);
        reset = 0;

        // Randomized phase, with one key pulse forced onto the position-update edge.
        pulse(0, 1, 0, 1, 0);
        begin
            int k = 0;
            while (!next_is_update() && k < FRAME_CYC + 10) begin @(negedge clk); k++; end
            pulse(1, 0, 1, 0, 0);
        end
        for (int c = 0; c < 4 * FRAME_CYC; c++) begin
            if ($urandom_range(0, 299) < 3) begin
                {bus.mv_up, bus.mv_dn, bus.mv_lf, bus.mv_rt, bus.stop} = 5'($urandom_range(1, 31));
            end
            bus.bm_we   = ($urandom_range(0, 39) == 0);
            bus.bm_row  = 3'($urandom);
            bus.bm_data = 8'($urandom);
            if ($urandom_range(0, 999) == 0) bus.fg_rgb = 9'($urandom);
            if ($urandom_range(0, 999) == 0) bus.border_rgb = 9'($urandom);
            if ($urandom_range(0, 999) == 0) bus.bounce_en = 1'($urandom);
            @(negedge clk);
            clear_inputs();
        end

        // Reset mid-frame while moving.
        bus.bounce_en = 1;
        pulse(0, 1, 0, 1, 0);
        wait_frame();
        wait_pixel(10, 15);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("rst_hs", int'(bus.vga_hs), 1);
        check("rst_vs", int'(bus.vga_vs), 0);
        check("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        check("rst_fs", int'(bus.frame_start), 0);
        check("rst_spr_x", int'(bus.spr_x), 13);
        check("rst_spr_y", int'(bus.spr_y), 9);

        // Rendering with the all-ones bitmap.
        bus.fg_rgb = 9'h1FF; bus.border_rgb = 9'h1C0;
        check_pix(0, 0, 9'h1C0);
        check_pix(13, 8, 9'h000);
        check_pix(12, 9, 9'h000);
        check_pix(13, 9, 9'h1FF);
        check_pix(21, 9, 9'h000);
        check_pix(20, 16, 9'h1FF);
        check_pix(20, 17, 9'h000);
        check_pix(31, 23, 9'h1C0);

        // Sync timing.
        measure(0, H_POL, H_TOTAL * CLK_DIV, H_PULSE * CLK_DIV, "hs");
        measure(1, V_POL, FRAME_CYC, V_PULSE * H_TOTAL * CLK_DIV, "vs");

        // Bitmap write and stop overriding a move.
        bus.bm_row = 3'd0; bus.bm_data = 8'h00; bus.bm_we = 1;
        @(negedge clk);
        bus.bm_we = 0;
        check_pix(13, 9, 9'h000);
        check_pix(14, 9, 9'h000);
        check_pix(13, 10, 9'h1FF);
        pulse(0, 1, 0, 0, 1);
        frames(2);
        check("stop_spr_y", int'(bus.spr_y), 9);
        check("stop_spr_x", int'(bus.spr_x), 13);

        // Clamp at the right edge.
        bus.bounce_en = 0;
        wait_frame();
        pulse(0, 0, 0, 1, 0);
        frames(5);
        check("clamp_x_f5", int'(bus.spr_x), 23);
        frames(1);
        check("clamp_x_f6", int'(bus.spr_x), 24);
        frames(1);
        check("clamp_x_f7", int'(bus.spr_x), 24);

        // Bounce at the left edge.
        bus.bounce_en = 1;
        pulse(0, 0, 1, 0, 0);
        frames(12);
        check("bounce_x_f12", int'(bus.spr_x), 0);
        frames(1);
        check("bounce_x_f13", int'(bus.spr_x), 0);
        frames(1);
        check("bounce_x_f14", int'(bus.spr_x), 2);
        check("bounce_y", int'(bus.spr_y), 9);

        repeat (4) @(negedge clk);
        finish_run();
    end
endmodule
